dmem_arbiter: RTL

Shares the single-ported data memory between the per-core load/store units of the multicore CPU. Each cycle it grants at most one requester using round-robin order. It drives the memory's byte-enable/address/write-data port and captures the combinational read data into a registered per-port response. A lock input keeps the grant on one port across consecutive cycles, so read-modify-write atomics are not interleaved with other cores.

---
 rtl/mem_pkg.sv | 6 +
 rtl/dmem_arbiter_if.sv | 30 +++
 rtl/dmem_arbiter_rr_arbiter.sv | 30 +++
 rtl/dmem_arbiter.sv | 108 ++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Data memory widths shared by the load/store path and the arbiter.
package mem_pkg;
  localparam int DATA_W           = 32;
  localparam int BE_W             = 4;
  localparam int DMEM_WORD_ADDR_W = 23;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bus between the cores' load/store units, the arbiter and the data memory.
interface dmem_arbiter_if
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        req_we;
  logic [BE_W*NUM_PORTS-1:0]   req_be;
  logic [DATA_W*NUM_PORTS-1:0] req_addr;
  logic [DATA_W*NUM_PORTS-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        req_lock;
  logic [NUM_PORTS-1:0]        resp_valid;
  logic [DATA_W*NUM_PORTS-1:0] resp_rdata;
  logic [BE_W-1:0]             mem_byte_enable;
  logic [DATA_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, req_lock, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_byte_enable, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, req_lock, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_byte_enable, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PORT_W-1:0]    grant_idx,
  output logic                 grant_any
);

  logic [PORT_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PORT_W'((int'(ptr) + k) % NUM_PORTS);
      if (!grant_any && req[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between cores,
// with a lock that pins the grant for read-modify-write sequences.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_arbiter_if.slave        bus
);

  logic [BE_W-1:0]   be_arr    [NUM_PORTS];
  logic [DATA_W-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];
  logic [DATA_W-1:0] rdata_q   [NUM_PORTS];

  logic [PORT_W-1:0]    rr_ptr;
  logic                 lock_active;
  logic [PORT_W-1:0]    lock_owner;
  logic [NUM_PORTS-1:0] resp_valid_q;

  logic [NUM_PORTS-1:0] rr_grant;
  logic [PORT_W-1:0]    rr_idx;
  logic                 rr_any;

  logic                 lock_hit;
  logic [NUM_PORTS-1:0] gnt_vec;
  logic [PORT_W-1:0]    gnt_idx;
  logic                 gnt_any;
  logic [PORT_W-1:0]    nxt_ptr;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign be_arr[i]    = bus.req_be[BE_W*i +: BE_W];
    assign addr_arr[i]  = bus.req_addr[DATA_W*i +: DATA_W];
    assign wdata_arr[i] = bus.req_wdata[DATA_W*i +: DATA_W];
    assign bus.resp_rdata[DATA_W*i +: DATA_W] = rdata_q[i];
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_rr (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_any (rr_any)
  );

  // A lock whose owner has dropped valid simply falls through to round-robin.
  assign lock_hit = lock_active && bus.req_valid[lock_owner];

  always_comb begin
    gnt_vec = rr_grant;
    gnt_idx = rr_idx;
    gnt_any = rr_any;
    if (lock_hit) begin
      gnt_vec             = '0;
      gnt_vec[lock_owner] = 1'b1;
      gnt_idx             = lock_owner;
      gnt_any             = 1'b1;
    end
  end

  assign bus.req_ready = gnt_vec;
  assign nxt_ptr = (gnt_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    bus.mem_byte_enable = '0;
    bus.mem_addr        = '0;
    bus.mem_wdata       = '0;
    if (gnt_any) begin
      bus.mem_addr  = addr_arr[gnt_idx];
      bus.mem_wdata = wdata_arr[gnt_idx];
      if (bus.req_we[gnt_idx]) bus.mem_byte_enable = be_arr[gnt_idx];
    end
  end

  // Loads and stores both capture mem_rdata; for a store that is the pre-write word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      lock_active  <= 1'b0;
      lock_owner   <= '0;
      resp_valid_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) rdata_q[i] <= '0;
    end else begin
      resp_valid_q <= gnt_vec;
      if (gnt_any) begin
        rr_ptr           <= nxt_ptr;
        rdata_q[gnt_idx] <= bus.mem_rdata;
        if (bus.req_lock[gnt_idx]) begin
          lock_active <= 1'b1;
          lock_owner  <= gnt_idx;
        end else begin
          lock_active <= 1'b0;
        end
      end else begin
        lock_active <= 1'b0;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;

endmodule
